// File: rtl/ccd_line2axis.sv
`default_nettype none
// ============================================================================
//  Module      : ccd_line2axis
//  Description : Linear-CCD line capture to AXI4-Stream. Detects line-start
//                edges, skips leading dummy pixels, captures the active pixels
//                and frames them (tuser = start of frame, tlast = end of line)
//                through a small show-ahead output FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
module ccd_line2axis #(
   parameter int D_WIDTH    = 12,
   parameter int OUT_WIDTH  = 8,
   parameter int LEAD_DUMMY = 32,
   parameter int ACTIVE_PIX = 2048,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic [11:0]          rows,
   input  logic                 line_start,
   input  logic                 pix_vld,
   input  logic [D_WIDTH-1:0]   pix_data,
   output logic [OUT_WIDTH-1:0] m_axis_tdata,
   output logic                 m_axis_tuser,
   output logic                 m_axis_tlast,
   output logic                 m_axis_tvalid,
   input  logic                 m_axis_tready,
   output logic                 overflow,
   output logic                 line_err
);

   localparam int CNT_MAX = (LEAD_DUMMY > ACTIVE_PIX) ? LEAD_DUMMY : ACTIVE_PIX;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int AW      = $clog2(FIFO_DEPTH);
   localparam int EW      = OUT_WIDTH + 2;
   localparam int LD_LAST = (LEAD_DUMMY > 0) ? LEAD_DUMMY - 1 : 0;

   localparam logic [CNT_W-1:0] C_LD_LAST = CNT_W'(LD_LAST);
   localparam logic [CNT_W-1:0] C_AP_LAST = CNT_W'(ACTIVE_PIX - 1);
   localparam logic [AW:0]      C_DEPTH   = (AW + 1)'(FIFO_DEPTH);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_DUMMY  = 2'd1;
   localparam logic [1:0] S_ACTIVE = 2'd2;
   // With no dummy pixels a line goes straight to capture
   localparam logic [1:0] S_START  = (LEAD_DUMMY == 0) ? S_ACTIVE : S_DUMMY;

   logic [1:0]       state_q, state_d;
   logic             ls_q;
   logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d;
   logic [11:0]      row_idx_q, row_idx_d;
   logic [11:0]      rows_l_q, rows_l_d;
   logic             overflow_q, line_err_q;

   logic [EW-1:0]    mem_q [FIFO_DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      count_q, count_d;

   logic             edge_w, start_w, dummy_done_w, act_vld_w, last_w, err_w;
   logic             full_w, wr_en_w, rd_en_w;
   logic [EW-1:0]    wr_entry_w, rd_entry_w;

   assign edge_w = line_start & ~ls_q;

   // State register and line-start edge history
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= S_IDLE;
         ls_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         ls_q    <= line_start;
      end
   end

   // Next-state: line start, dummy skip, active capture
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (edge_w) state_d = S_START;
         S_DUMMY:  if (pix_vld && (pix_cnt_q == C_LD_LAST)) state_d = S_ACTIVE;
         S_ACTIVE: if (pix_vld && (pix_cnt_q == C_AP_LAST)) state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // FSM-decoded control strobes and the FIFO entry for the current pixel
   always_comb begin
      start_w      = (state_q == S_IDLE) & edge_w;
      err_w        = (state_q != S_IDLE) & edge_w;
      dummy_done_w = (state_q == S_DUMMY) & pix_vld & (pix_cnt_q == C_LD_LAST);
      act_vld_w    = (state_q == S_ACTIVE) & pix_vld;
      last_w       = act_vld_w & (pix_cnt_q == C_AP_LAST);
      wr_entry_w   = {(row_idx_q == 12'd0) && (pix_cnt_q == '0),
                      pix_cnt_q == C_AP_LAST,
                      pix_data[D_WIDTH-1 -: OUT_WIDTH]};
   end

   // Pixel counter, row index and latched frame length for the next cycle
   always_comb begin
      pix_cnt_d = pix_cnt_q;
      row_idx_d = row_idx_q;
      rows_l_d  = rows_l_q;
      if (start_w) begin
         pix_cnt_d = '0;
         // Frame length is sampled only when a frame begins
         if (row_idx_q == 12'd0) rows_l_d = (rows == 12'd0) ? 12'd1 : rows;
      end else if (dummy_done_w || last_w) begin
         pix_cnt_d = '0;
      end else if ((state_q != S_IDLE) && pix_vld) begin
         pix_cnt_d = pix_cnt_q + CNT_W'(1);
      end
      if (last_w) row_idx_d = (row_idx_q == rows_l_q - 12'd1) ? 12'd0 : row_idx_q + 12'd1;
   end

   // Line/frame counters and sticky error flags
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         pix_cnt_q  <= '0;
         row_idx_q  <= 12'd0;
         rows_l_q   <= 12'd1;
         overflow_q <= 1'b0;
         line_err_q <= 1'b0;
      end else begin
         pix_cnt_q  <= pix_cnt_d;
         row_idx_q  <= row_idx_d;
         rows_l_q   <= rows_l_d;
         if (act_vld_w && full_w) overflow_q <= 1'b1;
         if (err_w)               line_err_q <= 1'b1;
      end
   end

   // Full is judged on the pre-read occupancy, so a full FIFO never accepts
   assign full_w  = (count_q == C_DEPTH);
   assign wr_en_w = act_vld_w & ~full_w;
   assign rd_en_w = m_axis_tvalid & m_axis_tready;

   // Occupancy update from the write/read pair
   always_comb begin
      count_d = count_q;
      case ({wr_en_w, rd_en_w})
         2'b10:   count_d = count_q + (AW + 1)'(1);
         2'b01:   count_d = count_q - (AW + 1)'(1);
         default: count_d = count_q;
      endcase
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (wr_en_w) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (rd_en_w) rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q <= count_d;
      end
   end

   // FIFO storage; contents are don't-care until written
   always_ff @(posedge clk) begin
      if (wr_en_w) mem_q[wr_ptr_q] <= wr_entry_w;
   end

   // Show-ahead head entry, forced to zero while the FIFO is empty
   assign rd_entry_w    = mem_q[rd_ptr_q];
   assign m_axis_tvalid = (count_q != '0);
   assign m_axis_tdata  = m_axis_tvalid ? rd_entry_w[OUT_WIDTH-1:0] : '0;
   assign m_axis_tlast  = m_axis_tvalid & rd_entry_w[OUT_WIDTH];
   assign m_axis_tuser  = m_axis_tvalid & rd_entry_w[OUT_WIDTH+1];
   assign overflow      = overflow_q;
   assign line_err      = line_err_q;

endmodule
`default_nettype wire
